// File: rtl/ethernet_smi_scheduler_if.sv
// Bundle between the SMI scheduler, the CSR-side CPU requester and the SMI shift unit.
// Handshakes: a command moves on the edge where its valid and ready are both 1. The
// payload stays stable while valid waits for ready. Response and receive valids are
// single-cycle pulses with no back-pressure.
interface ethernet_smi_scheduler_if;
  logic        cpuReqValid;
  logic        cpuReqReady;
  logic        cpuReqWrite;
  logic [4:0]  cpuReqPhy;
  logic [4:0]  cpuReqReg;
  logic [15:0] cpuReqData;
  logic        cpuRspValid;
  logic [15:0] cpuRspData;
  logic        pollEnable;
  logic [15:0] linkStatus;
  logic        linkUp;
  logic        linkChange;
  logic        busy;
  logic [31:0] smiTransmitData;
  logic        smiTransmitValid;
  logic        smiTransmitReady;
  logic [15:0] smiReceiveData;
  logic        smiReceiveValid;
  logic        smiBusy;

  modport slave (
    input  cpuReqValid, cpuReqWrite, cpuReqPhy, cpuReqReg, cpuReqData, pollEnable,
    input  smiTransmitReady, smiReceiveData, smiReceiveValid, smiBusy,
    output cpuReqReady, cpuRspValid, cpuRspData, linkStatus, linkUp, linkChange, busy,
    output smiTransmitData, smiTransmitValid
  );

  modport master (
    output cpuReqValid, cpuReqWrite, cpuReqPhy, cpuReqReg, cpuReqData, pollEnable,
    output smiTransmitReady, smiReceiveData, smiReceiveValid, smiBusy,
    input  cpuReqReady, cpuRspValid, cpuRspData, linkStatus, linkUp, linkChange, busy,
    input  smiTransmitData, smiTransmitValid
  );
endinterface

// File: rtl/ethernet_smi_scheduler.sv
// Arbitrates the SMI shift unit between CPU register commands and a periodic PHY
// status poller, building preamble and command frames and routing read data back.
module ethernet_smi_scheduler #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [4:0]  POLL_REG    = 5'd1,
  parameter int unsigned POLL_PERIOD = 1000000,
  parameter bit          PREAMBLE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  ethernet_smi_scheduler_if.slave bus,
  output logic [2:0]              fsm_state
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(POLL_PERIOD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRE_REQ  = 3'd1;
  localparam logic [2:0] S_PRE_WAIT = 3'd2;
  localparam logic [2:0] S_CMD_REQ  = 3'd3;
  localparam logic [2:0] S_CMD_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] poll_timer;
  logic          poll_pending;
  logic          ptr_poll;
  logic          grant_cpu;
  logic          grant_poll;
  logic          cur_cpu;
  logic          cur_write;
  logic [4:0]    cur_phy;
  logic [4:0]    cur_reg;
  logic [15:0]   cur_data;
  logic [15:0]   rx_data;
  logic [15:0]   rd_value;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          rsp_valid;
  logic [15:0]   rsp_data;
  logic [15:0]   link_status;
  logic          link_up;
  logic          link_change;
  logic          sel_write;
  logic [4:0]    sel_phy;
  logic [4:0]    sel_reg;

  function automatic logic [31:0] cmd_frame(input logic wr, input logic [4:0] phy,
                                            input logic [4:0] rg, input logic [15:0] d);
    return {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, (wr ? d : 16'h0000)};
  endfunction

  // ptr_poll picks the winner only when both sides are pending.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_poll = 1'b0;
    if (state == S_IDLE) begin
      if (bus.cpuReqValid && (!poll_pending || !ptr_poll)) grant_cpu = 1'b1;
      else if (poll_pending)                                grant_poll = 1'b1;
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_phy   = PHY_ADDR;
    sel_reg   = POLL_REG;
    if (grant_cpu) begin
      sel_write = bus.cpuReqWrite;
      sel_phy   = bus.cpuReqPhy;
      sel_reg   = bus.cpuReqReg;
    end
  end

  // Read data may arrive on the same cycle smiBusy drops, so bypass the capture register.
  assign rd_value = bus.smiReceiveValid ? bus.smiReceiveData : rx_data;

  // A fresh expiry on the grant cycle re-arms the request rather than being lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_timer   <= RELOAD;
      poll_pending <= 1'b0;
    end else if (!bus.pollEnable) begin
      poll_timer   <= RELOAD;
      poll_pending <= 1'b0;
    end else begin
      if (grant_poll) poll_pending <= 1'b0;
      if (poll_timer == '0) begin
        poll_timer   <= RELOAD;
        poll_pending <= 1'b1;
      end else begin
        poll_timer <= poll_timer - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr_poll    <= 1'b0;
      cur_cpu     <= 1'b0;
      cur_write   <= 1'b0;
      cur_phy     <= '0;
      cur_reg     <= '0;
      cur_data    <= '0;
      rx_data     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      link_status <= '0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      link_change <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_cpu || grant_poll) begin
            cur_cpu   <= grant_cpu;
            cur_write <= sel_write;
            cur_phy   <= sel_phy;
            cur_reg   <= sel_reg;
            cur_data  <= bus.cpuReqData;
            ptr_poll  <= grant_cpu;
            tx_valid  <= 1'b1;
            if (PREAMBLE_EN) begin
              tx_data <= 32'hFFFF_FFFF;
              state   <= S_PRE_REQ;
            end else begin
              tx_data <= cmd_frame(sel_write, sel_phy, sel_reg, bus.cpuReqData);
              state   <= S_CMD_REQ;
            end
          end
        end
        S_PRE_REQ: begin
          if (bus.smiTransmitReady) begin
            tx_valid <= 1'b0;
            state    <= S_PRE_WAIT;
          end
        end
        S_PRE_WAIT: begin
          if (!bus.smiBusy) begin
            tx_data  <= cmd_frame(cur_write, cur_phy, cur_reg, cur_data);
            tx_valid <= 1'b1;
            state    <= S_CMD_REQ;
          end
        end
        S_CMD_REQ: begin
          if (bus.smiTransmitReady) begin
            tx_valid <= 1'b0;
            state    <= S_CMD_WAIT;
          end
        end
        S_CMD_WAIT: begin
          if (bus.smiReceiveValid) rx_data <= bus.smiReceiveData;
          if (!bus.smiBusy) begin
            state <= S_DONE;
            if (cur_cpu) begin
              rsp_valid <= 1'b1;
              if (!cur_write) rsp_data <= rd_value;
            end else begin
              link_status <= rd_value;
              link_up     <= rd_value[2];
              link_change <= rd_value[2] ^ link_up;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpuReqReady      = grant_cpu;
  assign bus.cpuRspValid      = rsp_valid;
  assign bus.cpuRspData       = rsp_data;
  assign bus.linkStatus       = link_status;
  assign bus.linkUp           = link_up;
  assign bus.linkChange       = link_change;
  assign bus.busy             = (state != S_IDLE);
  assign bus.smiTransmitData  = tx_data;
  assign bus.smiTransmitValid = tx_valid;
  assign fsm_state            = state;
endmodule

// File: doc/ethernet_smi_scheduler.md
# ethernet_smi_scheduler

Sequences and arbitrates the Ethernet SMI (MDIO) shift unit between CPU register requests and an autonomous PHY link-status poller. Builds 32-bit management frames (optional all-ones preamble frame, then the command frame), drives the SMI unit's valid/ready/receive-valid handshake, and returns read data to the winning requester. Sits between the CSR block and the SMI shift unit inside the Ethernet MAC subsystem.

## Interface
- PHY_ADDR, 5'd1, PHY address used by the poller
- POLL_REG, 5'd1, register polled (BMSR)
- POLL_PERIOD, 1000000, clk cycles between poll requests (>= 2)
- PREAMBLE_EN, 1, 1 = send a 32'hFFFF_FFFF frame before every command frame
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpuReqValid  in  1  CPU command pending
- cpuReqReady  out  1  one-cycle accept strobe for the CPU command
- cpuReqWrite  in  1  1 = write, 0 = read
- cpuReqPhy  in  5  PHY address
- cpuReqReg  in  5  register address
- cpuReqData  in  16  write data
- cpuRspValid  out  1  one-cycle pulse on CPU command completion
- cpuRspData  out  16  read data (unchanged on writes)
- pollEnable  in  1  enables periodic polling
- linkStatus  out  16  last polled register value
- linkUp  out  1  linkStatus[2]
- linkChange  out  1  one-cycle pulse when linkUp changes
- busy  out  1  scheduler not in IDLE
- smiTransmitData  out  32  frame to SMI unit
- smiTransmitValid  out  1  frame valid
- smiTransmitReady  in  1  SMI unit accepted frame
- smiReceiveData  in  16  read data from SMI unit
- smiReceiveValid  in  1  read data valid pulse
- smiBusy  in  1  SMI unit busy

## Operation
- Reset values: all outputs 0; state IDLE; poll timer = POLL_PERIOD-1; pollPending 0; grant pointer = CPU.
- Frame format: {2'b01, op, phy[4:0], reg[4:0], 2'b10, data[15:0]}; op 2'b01 write, 2'b10 read; read data field 16'h0000.
- Poll timer: counts down while pollEnable=1; at 0 sets pollPending and reloads POLL_PERIOD-1. Expiry while pending: no effect. pollEnable=0: timer held at reload, pollPending cleared.
- Arbitration in IDLE: only one request pending -> grant it; both pending -> grant per pointer, pointer flips to the other requester after each grant. After reset, CPU first.
- CPU grant: cpuReqReady=1 for that cycle (combinational, IDLE only); command fields latched.
- States: IDLE -> PRE_REQ (if PREAMBLE_EN) or CMD_REQ. PRE_REQ/CMD_REQ: smiTransmitValid=1 with frame held stable until smiTransmitReady seen -> PRE_WAIT/CMD_WAIT. WAIT states: stay while smiBusy=1; on smiBusy=0 PRE_WAIT -> CMD_REQ, CMD_WAIT -> DONE. DONE -> IDLE (one cycle).
- Read capture: smiReceiveData latched on smiReceiveValid in CMD_WAIT; smiReceiveValid outside CMD_WAIT ignored.
- DONE for CPU: cpuRspValid=1, cpuRspData = captured data (reads only). DONE for poll: linkStatus = captured data, linkUp = bit 2, linkChange=1 if bit 2 differs from previous linkUp; pollPending cleared at grant.

## Timing
- smiTransmitValid rises the cycle after grant (registered); falls on the edge where smiTransmitReady=1 is sampled.
- SMI unit raises smiBusy the same cycle it pulses smiTransmitReady; WAIT never exits on the ready cycle.
- cpuReqReady to cpuRspValid: frame time(s) + 3 scheduler cycles.
- Back-to-back: a new grant occurs no earlier than the cycle after DONE.
- Reset asserted mid-transaction: all registers to reset values immediately; in-flight response discarded, no cpuRspValid.

## Test plan
- PREAMBLE_EN=1, CPU write phy 1 reg 0 data 16'h1200 -> frames 32'hFFFF_FFFF then 32'h5082_1200; cpuRspValid one pulse; cpuRspData unchanged.
- CPU read phy 1 reg 1, SMI model returns 16'h782D -> frame 32'h6086_0000, cpuRspData=16'h782D.
- POLL_PERIOD=100, pollEnable=1, model returns 16'h0004 then 16'h0000 -> poll frame 32'h6086_0000 every ~100 cycles; linkUp 0->1->0, linkChange pulsed twice.
- CPU request and pollPending simultaneous, repeated -> grants alternate CPU, poll, CPU, poll.
- Reset low during CMD_WAIT of a CPU read -> smiTransmitValid, busy, cpuRspValid 0; no response after release; timer restarts at 99.
- smiTransmitReady delayed 10 cycles -> smiTransmitData/Valid stable all 10 cycles; single frame issued.
